// File: rtl/modadder_stream_seq.sv
// modadder_stream_seq: word-serial loader/unloader around the 381-bit modadder core
// Commands (cmd_*) start a job.
// Operands A, B and M then arrive least-significant word first on s_* (valid/ready).
// The core is driven through add_* (single-cycle add_start, result taken on add_done).
// The result leaves on m_* (valid/ready, m_last on the final word).
// busy is high whenever the sequencer is not idle. resetn is synchronous and active-low.
// Optional KEEP_MODULUS_EN: when defined, add_m persists across commands.
// In that build, cmd_load_m=0 skips the M words.
module modadder_stream_seq #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 381,
  parameter int NWORDS = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_subtract,
  input  logic              cmd_load_m,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              add_start,
  output logic              add_subtract,
  output logic [OP_W-1:0]   add_a,
  output logic [OP_W-1:0]   add_b,
  output logic [OP_W-1:0]   add_m,
  input  logic [OP_W-1:0]   add_result,
  input  logic              add_done
);
  localparam int CW = $clog2(NWORDS);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_M, START, WAIT, SEND} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [OP_W-1:0] res;
  logic last_word;
  assign last_word = cnt == CW'(NWORDS - 1);
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign s_ready   = state inside {LOAD_A, LOAD_B, LOAD_M};
  assign m_valid   = state == SEND;
  assign m_last    = m_valid & last_word;
  assign add_start = state == START;
`ifdef KEEP_MODULUS_EN
  logic load_m;
`else
  logic unused_load_m;
  assign unused_load_m = cmd_load_m;
`endif
  // Bits of the top word beyond OP_W are dropped.
  function automatic logic [OP_W-1:0] put_word(input logic [OP_W-1:0] v, input logic [CW-1:0] k,
                                               input logic [WORD_W-1:0] d);
    logic [OP_W-1:0] r;
    r = v;
    for (int i = 0; i < OP_W; i++)
      if (i / WORD_W == int'(k)) r[i] = d[i % WORD_W];
    return r;
  endfunction
  // The top output word is zero-extended past OP_W.
  always_comb begin
    m_data = '0;
    for (int i = 0; i < WORD_W; i++)
      if (int'(cnt) * WORD_W + i < OP_W) m_data[i] = res[int'(cnt) * WORD_W + i];
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      res          <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_m        <= '0;
      add_subtract <= 1'b0;
`ifdef KEEP_MODULUS_EN
      load_m       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state        <= LOAD_A;
          add_subtract <= cmd_subtract;
`ifdef KEEP_MODULUS_EN
          load_m       <= cmd_load_m;
`endif
        end
        LOAD_A: if (s_valid) begin
          add_a <= put_word(add_a, cnt, s_data);
          cnt   <= last_word ? '0 : cnt + 1'b1;
          if (last_word) state <= LOAD_B;
        end
        LOAD_B: if (s_valid) begin
          add_b <= put_word(add_b, cnt, s_data);
          cnt   <= last_word ? '0 : cnt + 1'b1;
`ifdef KEEP_MODULUS_EN
          if (last_word) state <= load_m ? LOAD_M : START;
`else
          if (last_word) state <= LOAD_M;
`endif
        end
        LOAD_M: if (s_valid) begin
          add_m <= put_word(add_m, cnt, s_data);
          cnt   <= last_word ? '0 : cnt + 1'b1;
          if (last_word) state <= START;
        end
        START: state <= WAIT;
        WAIT: if (add_done) begin
          res   <= add_result;
          state <= SEND;
        end
        SEND: if (m_ready) begin
          cnt <= last_word ? '0 : cnt + 1'b1;
          if (last_word) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modadder_stream_seq.sv
// tb_modadder_stream_seq: directed scoreboard bench for modadder_stream_seq with a behavioural core
module tb_modadder_stream_seq;
  localparam int W = 32, OW = 381, N = 12;
  localparam logic [OW-1:0] P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  logic clk = 1'b0;
  logic resetn, cmd_valid, cmd_ready, cmd_subtract, cmd_load_m;
  logic s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic add_start, add_subtract, add_done;
  logic [W-1:0] s_data, m_data;
  logic [OW-1:0] add_a, add_b, add_m, add_result;
  logic [W-1:0] q[$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  modadder_stream_seq dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_subtract(cmd_subtract), .cmd_load_m(cmd_load_m),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .add_start(add_start), .add_subtract(add_subtract),
    .add_a(add_a), .add_b(add_b), .add_m(add_m), .add_result(add_result), .add_done(add_done)
  );
  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask
  task automatic push_res(input logic [OW-1:0] r);
    logic [N*W-1:0] t;
    t = {3'b000, r};
    for (int i = 0; i < N; i++) q.push_back(t[i*W +: W]);
  endtask
  task automatic do_cmd(input logic sub, input logic lm);
    chkb("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_subtract = sub;
    cmd_load_m = lm;
    @(negedge clk);
    cmd_valid = 1'b0;
    chkb("s_ready_load", s_ready, 1'b1);
  endtask
  task automatic send_op(input logic [OW-1:0] v, input logic [2:0] hi = 3'b000,
                         input int gap_at = -1, input int gap_len = 0);
    logic [N*W-1:0] t;
    t = {hi, v};
    for (int k = 0; k < N; k++) begin
      if (k == gap_at) begin
        s_valid = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data = t[k*W +: W];
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data = '0;
  endtask
  task automatic wait_start();
    int n = 0;
    while (!add_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chkb("add_start_seen", add_start, 1'b1);
  endtask
  task automatic core(input int lat);
    logic [OW:0] s;
    logic [OW-1:0] r;
    wait_start();
    @(negedge clk);
    chkb("add_start_one_cycle", add_start, 1'b0);
    if (add_subtract) r = (add_a >= add_b) ? add_a - add_b : OW'({1'b0, add_a} + {1'b0, add_m} - {1'b0, add_b});
    else begin
      s = {1'b0, add_a} + {1'b0, add_b};
      r = (s >= {1'b0, add_m}) ? OW'(s - {1'b0, add_m}) : OW'(s);
    end
    repeat (lat) @(negedge clk);
    add_done = 1'b1;
    add_result = r;
    @(negedge clk);
    add_done = 1'b0;
  endtask
  task automatic recv(input int stall_at = -1, input int stall_len = 0);
    logic [W-1:0] exp;
    for (int k = 0; k < N; k++) begin
      int n = 0;
      while (!m_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chkb("m_valid", m_valid, 1'b1);
      chkb("sb_underflow", q.size() == 0, 1'b0);
      exp = (q.size() != 0) ? q.pop_front() : '0;
      chk($sformatf("m_data[%0d]", k), OW'(m_data), OW'(exp));
      chkb($sformatf("m_last[%0d]", k), m_last, k == N - 1);
      if (k == stall_at) begin
        m_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          chk("m_data_held", OW'(m_data), OW'(exp));
          chkb("m_valid_held", m_valid, 1'b1);
        end
      end
      m_ready = 1'b1;
      @(negedge clk);
    end
    m_ready = 1'b0;
    chkb("idle_after_send", busy, 1'b0);
    chkb("m_valid_after_send", m_valid, 1'b0);
  endtask
  initial begin
    resetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_subtract = 1'b0;
    cmd_load_m = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    add_done = 1'b0;
    add_result = '0;
    repeat (2) @(negedge clk);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_cmd_ready", cmd_ready, 1'b1);
    chkb("rst_s_ready", s_ready, 1'b0);
    chkb("rst_m_valid", m_valid, 1'b0);
    chkb("rst_add_start", add_start, 1'b0);
    chkb("rst_add_subtract", add_subtract, 1'b0);
    chk("rst_add_a", add_a, '0);
    chk("rst_add_m", add_m, '0);
    chk("rst_m_data", OW'(m_data), '0);
    resetn = 1'b1;
    @(negedge clk);
    // 1 + 1 mod p
    push_res(OW'(2));
    do_cmd(1'b0, 1'b1);
    send_op(OW'(1));
    send_op(OW'(1));
    send_op(P);
    core(3);
    recv();
    // 1 - 2 mod p = p - 1
    push_res(P - OW'(1));
    do_cmd(1'b1, 1'b1);
    send_op(OW'(1));
    send_op(OW'(2));
    send_op(P);
    chkb("add_subtract_latched", add_subtract, 1'b1);
    core(2);
    recv();
    // top word of A is all ones on the wire; only 29 bits may land
    push_res({29'h1FFFFFFF, 352'b0});
    do_cmd(1'b0, 1'b1);
    send_op({29'h1FFFFFFF, 352'b0}, 3'b111);
    send_op('0);
    send_op({OW{1'b1}});
    chk("mask_add_a", add_a, {29'h1FFFFFFF, 352'b0});
    core(1);
    recv();
    // input gap in LOAD_B and output stall at word 4
    push_res(OW'(4));
    do_cmd(1'b0, 1'b1);
    send_op(P - OW'(1));
    send_op(OW'(5), 3'b000, 5, 3);
    send_op(P);
    chk("bp_add_b", add_b, OW'(5));
    core(4);
    recv(4, 5);
    // reset while waiting for the core, then a stale done
    do_cmd(1'b0, 1'b1);
    send_op(OW'(3));
    send_op(OW'(4));
    send_op(P);
    wait_start();
    @(negedge clk);
    chkb("wait_busy", busy, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chkb("abort_busy", busy, 1'b0);
    chkb("abort_cmd_ready", cmd_ready, 1'b1);
    chkb("abort_m_valid", m_valid, 1'b0);
    chk("abort_add_a", add_a, '0);
    add_done = 1'b1;
    add_result = OW'(7);
    @(negedge clk);
    add_done = 1'b0;
    repeat (3) @(negedge clk);
    chkb("late_done_m_valid", m_valid, 1'b0);
    chkb("late_done_busy", busy, 1'b0);
`ifdef KEEP_MODULUS_EN
    push_res(OW'(2));
    do_cmd(1'b0, 1'b1);
    send_op(OW'(1));
    send_op(OW'(1));
    send_op(P);
    core(2);
    recv();
    push_res(OW'(1));
    do_cmd(1'b0, 1'b0);
    send_op(P - OW'(1));
    send_op(OW'(2));
    chkb("keep_s_ready_drop", s_ready, 1'b0);
    chk("keep_add_m", add_m, P);
    core(2);
    recv();
`endif
    chkb("sb_drained", q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
